// File: rtl/alu_cmd_issuer_pkg.sv
// ============================================================================
// Module : alu_cmd_issuer_pkg
// Brief  : Shared FSM state encoding and default sizing for alu_cmd_issuer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package alu_cmd_issuer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int c_DEF_OUT_WIDTH     = 8;
  localparam int c_DEF_ALU_FUN_WIDTH = 4;
  localparam int c_DEF_TIMEOUT       = 15;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_issuer.sv
// ============================================================================
// Module : alu_cmd_issuer
// Brief  : Issues one latched command to an external ALU, waits for its
//          result (bounded by TIMEOUT) and presents it as a response.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module alu_cmd_issuer
  import alu_cmd_issuer_pkg::*;
#(
  parameter int OUT_WIDTH     = c_DEF_OUT_WIDTH,
  parameter int ALU_FUN_WIDTH = c_DEF_ALU_FUN_WIDTH,
  parameter int TIMEOUT       = c_DEF_TIMEOUT
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [ALU_FUN_WIDTH-1:0] CMD_FUN,
  input  logic [OUT_WIDTH-1:0]     CMD_A,
  input  logic [OUT_WIDTH-1:0]     CMD_B,
  output logic                     ALU_EN,
  output logic [ALU_FUN_WIDTH-1:0] ALU_FUN,
  output logic [OUT_WIDTH-1:0]     A,
  output logic [OUT_WIDTH-1:0]     B,
  input  logic [OUT_WIDTH-1:0]     ALU_OUT,
  input  logic                     OUT_VALID,
  output logic                     RSP_VALID,
  input  logic                     RSP_READY,
  output logic [OUT_WIDTH-1:0]     RSP_DATA,
  output logic                     RSP_ERR
);

  localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t                   state_q,    state_d;
  logic [CNT_W-1:0]         cnt_q,      cnt_d;
  logic [ALU_FUN_WIDTH-1:0] alu_fun_q,  alu_fun_d;
  logic [OUT_WIDTH-1:0]     a_q,        a_d;
  logic [OUT_WIDTH-1:0]     b_q,        b_d;
  logic [OUT_WIDTH-1:0]     rsp_data_q, rsp_data_d;
  logic                     rsp_err_q,  rsp_err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      alu_fun_q  <= '0;
      a_q        <= '0;
      b_q        <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      alu_fun_q  <= alu_fun_d;
      a_q        <= a_d;
      b_q        <= b_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    alu_fun_d  = alu_fun_q;
    a_d        = a_q;
    b_d        = b_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (CMD_VALID) begin
          alu_fun_d = CMD_FUN;
          a_d       = CMD_A;
          b_d       = CMD_B;
          cnt_d     = '0;
          state_d   = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // OUT_VALID on the first EXEC cycle may be left over from a prior op.
        if ((cnt_q != '0) && OUT_VALID) begin
          rsp_data_d = ALU_OUT;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else if (cnt_q == CNT_LAST) begin
          rsp_data_d = '0;
          rsp_err_d  = 1'b1;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (RSP_READY) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign CMD_READY = (state_q == ST_IDLE);
  assign ALU_EN    = (state_q == ST_EXEC);
  assign RSP_VALID = (state_q == ST_RESP);
  assign ALU_FUN   = alu_fun_q;
  assign A         = a_q;
  assign B         = b_q;
  assign RSP_DATA  = rsp_data_q;
  assign RSP_ERR   = rsp_err_q;

endmodule

`default_nettype wire

// File: doc/alu_cmd_issuer.md
ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

Interface
REQ-001 Parameter OUT_WIDTH, default 8: operand and result width.
REQ-002 Parameter ALU_FUN_WIDTH, default 4: ALU function code width.
REQ-003 Parameter TIMEOUT, default 15, legal range 2..255: max EXEC cycles before error.
REQ-004 CLK  in  1  single clock; all logic rising-edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 CMD_VALID  in  1  command request.
REQ-007 CMD_READY  out  1  issuer accepts command.
REQ-008 CMD_FUN  in  ALU_FUN_WIDTH  requested function.
REQ-009 CMD_A, CMD_B  in  OUT_WIDTH each  operands.
REQ-010 ALU_EN  out  1  ALU enable, held high for the whole operation.
REQ-011 ALU_FUN  out  ALU_FUN_WIDTH  latched function to ALU.
REQ-012 A, B  out  OUT_WIDTH each  latched operands to ALU.
REQ-013 ALU_OUT  in  OUT_WIDTH  registered ALU result.
REQ-014 OUT_VALID  in  1  registered ALU result valid.
REQ-015 RSP_VALID  out  1  response available.
REQ-016 RSP_READY  in  1  consumer accepts response.
REQ-017 RSP_DATA  out  OUT_WIDTH  captured result.
REQ-018 RSP_ERR  out  1  timeout flag for this response.

Function
REQ-019 FSM states: IDLE, EXEC, RESP; register-based state, encoding from the shared package.
REQ-020 CMD_READY SHALL be 1 only in IDLE; command accepted when CMD_VALID & CMD_READY at a rising edge.
REQ-021 On acceptance: latch CMD_FUN/CMD_A/CMD_B into ALU_FUN/A/B, clear cycle counter, go to EXEC.
REQ-022 ALU_FUN, A, B SHALL stay constant from acceptance until the next acceptance.
REQ-023 ALU_EN SHALL be 1 exactly while in EXEC, 0 in IDLE and RESP.
REQ-024 In EXEC the counter increments each cycle; OUT_VALID is ignored when counter = 0 (stale-flag guard).
REQ-025 In EXEC with counter >= 1 and OUT_VALID=1: RSP_DATA <= ALU_OUT, RSP_ERR <= 0, go to RESP.
REQ-026 In EXEC with counter = TIMEOUT-1 and OUT_VALID=0: RSP_DATA <= 0, RSP_ERR <= 1, go to RESP.
REQ-027 Simultaneous OUT_VALID and timeout condition: valid result wins, RSP_ERR=0.
REQ-028 RSP_VALID SHALL be 1 exactly in RESP; RSP_DATA/RSP_ERR held stable while RSP_VALID=1.
REQ-029 In RESP, RSP_READY=1 at an edge returns to IDLE; no new command accepted in that same edge.
REQ-030 OUT_VALID in IDLE or RESP SHALL be ignored.
REQ-031 Minimum latency: acceptance at edge t, ALU_EN high t..t+1, earliest RSP_VALID after edge t+2.
REQ-032 Counter width ceil(log2(TIMEOUT)) bits; SHALL never wrap within one operation.

Reset
REQ-033 RST=1 at an edge: state IDLE, counter 0, ALU_EN 0, ALU_FUN/A/B 0, RSP_DATA 0, RSP_ERR 0, RSP_VALID 0, CMD_READY 1 from the next cycle.
REQ-034 RST mid-EXEC or mid-RESP SHALL abort the operation and discard any pending response; RST overrides all other inputs.

Structure
REQ-035 Shared package holds: FSM state typedef/constants, default TIMEOUT, default OUT_WIDTH/ALU_FUN_WIDTH.
REQ-036 Single module, no sub-modules; counter and FSM inline.

Verification
REQ-037 Accept FUN=0x0, A=0x05, B=0x03; ALU returns OUT_VALID with ALU_OUT=0x08 two cycles after acceptance -> RSP_VALID, RSP_DATA=0x08, RSP_ERR=0, ALU_EN high exactly 2 cycles.
REQ-038 OUT_VALID never asserted, TIMEOUT=15 -> ALU_EN high 15 cycles, then RSP_VALID with RSP_DATA=0x00, RSP_ERR=1.
REQ-039 OUT_VALID=1 with ALU_OUT=0xAA on the cycle where counter = TIMEOUT-1 -> RSP_DATA=0xAA, RSP_ERR=0.
REQ-040 RSP_READY held 0 for 5 cycles with CMD_VALID=1 -> RSP_DATA stable, CMD_READY=0 throughout; command accepted only after the cycle following the RSP handshake.
REQ-041 OUT_VALID=1 in IDLE and in first EXEC cycle -> no response generated from it.
REQ-042 RST=1 during EXEC counter = 4 -> next cycle IDLE, ALU_EN=0, RSP_VALID=0, all outputs at reset values.
